// File: rtl/uart_pkg.sv
// Shared constants and types for the UART debug transport: TAP register
// addresses, DMI op/status encodings, DTMCS field positions and DTM states.
package uart_pkg;

   localparam int IRLENGTH = 5;

   localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
   localparam logic [IRLENGTH-1:0] ADDR_DTMCS  = 5'h10;
   localparam logic [IRLENGTH-1:0] ADDR_DMI    = 5'h11;

   typedef enum logic [1:0] {
      DMI_OP_NOP   = 2'd0,
      DMI_OP_READ  = 2'd1,
      DMI_OP_WRITE = 2'd2
   } dmi_op_e;

   typedef enum logic [1:0] {
      DMI_STATUS_OK     = 2'd0,
      DMI_STATUS_FAILED = 2'd2,
      DMI_STATUS_BUSY   = 2'd3
   } dmi_status_e;

   localparam int DTMCS_VERSION_LSB      = 0;
   localparam int DTMCS_ABITS_LSB        = 4;
   localparam int DTMCS_DMISTAT_LSB      = 10;
   localparam int DTMCS_IDLE_LSB         = 12;
   localparam int DTMCS_DMIHARDRESET_BIT = 16;
   localparam int DTMCS_DMIRESET_BIT     = 17;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } dtm_state_e;

endpackage

// File: rtl/dmi_uart_dtm_ctrl.sv
// DTM register controller: serves TAP reads/writes of IDCODE, DTMCS and DMI,
// runs one DMI request/response at a time and keeps the sticky DMI error.
module dmi_uart_dtm_ctrl
   import uart_pkg::*;
#(
   parameter int          WIDTH        = 41,
   parameter int          ABITS        = 7,
   parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
   input  logic                CLK_I,
   input  logic                RST_NI,
   input  logic [IRLENGTH-1:0] WRITE_ADDRESS_I,
   input  logic [WIDTH-1:0]    WRITE_DATA_I,
   input  logic                WRITE_VALID_I,
   output logic                WRITE_READY_O,
   input  logic [IRLENGTH-1:0] READ_ADDRESS_I,
   input  logic                READ_READY_I,
   output logic [WIDTH-1:0]    READ_DATA_O,
   output logic                READ_VALID_O,
   output logic [IRLENGTH-1:0] VALID_ADDRESS_O,
   input  logic                DMI_HARD_RESET_I,
   output logic [1:0]          DMI_ERROR_O,
   output logic [ABITS-1:0]    DMI_REQ_ADDR_O,
   output logic [31:0]         DMI_REQ_DATA_O,
   output logic [1:0]          DMI_REQ_OP_O,
   output logic                DMI_REQ_VALID_O,
   input  logic                DMI_REQ_READY_I,
   input  logic [31:0]         DMI_RESP_DATA_I,
   input  logic [1:0]          DMI_RESP_OP_I,
   input  logic                DMI_RESP_VALID_I,
   output logic                DMI_RESP_READY_O
);

   dtm_state_e       state, state_d;
   logic             drain_q, drain_d;
   logic [1:0]       err_q, err_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             read_pending_q;

   logic             write_fire, dmi_write, dtmcs_write;
   logic             hard_reset, dmi_reset, launch, busy_write;
   logic             resp_fire, capture, leaving_busy, read_accept, defer_read;
   logic [1:0]       wr_op, resp_op_eff;
   logic [WIDTH-1:0] dmi_read_word, dtmcs_word, read_word;

   assign WRITE_READY_O    = (state != ST_REQ);
   assign DMI_RESP_READY_O = (state == ST_RESP);
   assign DMI_ERROR_O      = err_q;

   assign wr_op       = WRITE_DATA_I[1:0];
   assign write_fire  = WRITE_VALID_I & WRITE_READY_O;
   assign dmi_write   = write_fire && (WRITE_ADDRESS_I == ADDR_DMI);
   assign dtmcs_write = write_fire && (WRITE_ADDRESS_I == ADDR_DTMCS);
   assign hard_reset  = DMI_HARD_RESET_I | (dtmcs_write & WRITE_DATA_I[DTMCS_DMIHARDRESET_BIT]);
   assign dmi_reset   = dtmcs_write & WRITE_DATA_I[DTMCS_DMIRESET_BIT];
   assign launch      = (state == ST_IDLE) && dmi_write && !hard_reset && (err_q == 2'd0) &&
                        ((wr_op == DMI_OP_READ) || (wr_op == DMI_OP_WRITE));
   assign busy_write  = (state == ST_RESP) && dmi_write && !hard_reset;
   assign resp_fire   = (state == ST_RESP) && DMI_RESP_VALID_I;
   // A response that was outstanding across a hard reset is drained but never recorded.
   assign capture     = resp_fire && !drain_q && !hard_reset;
   assign resp_op_eff = (err_q != 2'd0) ? err_q : DMI_RESP_OP_I;

   always_comb begin
      state_d = state;
      drain_d = drain_q;
      case (state)
         ST_IDLE: begin
            drain_d = 1'b0;
            if (launch) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (hard_reset)           state_d = ST_IDLE;
            else if (DMI_REQ_READY_I) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_fire) begin
               state_d = ST_IDLE;
               drain_d = 1'b0;
            end else if (hard_reset) begin
               drain_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      err_d    = err_q;
      result_d = result_q;
      if (hard_reset || dmi_reset) begin
         err_d = 2'd0;
      end else if (err_q == 2'd0) begin
         if (busy_write)                    err_d = DMI_STATUS_BUSY;
         else if (capture && DMI_RESP_OP_I[1]) err_d = DMI_RESP_OP_I;
      end
      if (hard_reset)   result_d = '0;
      else if (capture) result_d = {DMI_REQ_ADDR_O, DMI_RESP_DATA_I, resp_op_eff};
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         state    <= ST_IDLE;
         drain_q  <= 1'b0;
         err_q    <= 2'd0;
         result_q <= '0;
      end else begin
         state    <= state_d;
         drain_q  <= drain_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         DMI_REQ_VALID_O <= 1'b0;
         DMI_REQ_ADDR_O  <= '0;
         DMI_REQ_DATA_O  <= '0;
         DMI_REQ_OP_O    <= 2'd0;
      end else if (launch) begin
         DMI_REQ_VALID_O <= 1'b1;
         DMI_REQ_ADDR_O  <= WRITE_DATA_I[WIDTH-1:34];
         DMI_REQ_DATA_O  <= WRITE_DATA_I[33:2];
         DMI_REQ_OP_O    <= wr_op;
      end else if (hard_reset || DMI_REQ_READY_I) begin
         DMI_REQ_VALID_O <= 1'b0;
      end
   end

   // DMI reads see this cycle's capture, so a response arriving alongside the read is returned.
   always_comb begin
      dmi_read_word = result_d;
      if (err_d != 2'd0) dmi_read_word[1:0] = err_d;
      dtmcs_word = '0;
      dtmcs_word[DTMCS_IDLE_LSB +: 3]    = 3'd1;
      dtmcs_word[DTMCS_DMISTAT_LSB +: 2] = err_q;
      dtmcs_word[DTMCS_ABITS_LSB +: 6]   = 6'(ABITS);
      dtmcs_word[DTMCS_VERSION_LSB +: 4] = 4'd1;
      case (READ_ADDRESS_I)
         ADDR_IDCODE: read_word = WIDTH'(IDCODE_VALUE);
         ADDR_DTMCS:  read_word = dtmcs_word;
         ADDR_DMI:    read_word = dmi_read_word;
         default:     read_word = '0;
      endcase
   end

   assign leaving_busy = (state != ST_IDLE) && (state_d == ST_IDLE);
   assign read_accept  = READ_READY_I && !read_pending_q && !READ_VALID_O;
   assign defer_read   = (READ_ADDRESS_I == ADDR_DMI) && (state != ST_IDLE) && (state_d != ST_IDLE);

   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         READ_VALID_O    <= 1'b0;
         READ_DATA_O     <= '0;
         VALID_ADDRESS_O <= '0;
         read_pending_q  <= 1'b0;
      end else begin
         READ_VALID_O <= 1'b0;
         if (read_pending_q && leaving_busy) begin
            READ_VALID_O    <= 1'b1;
            READ_DATA_O     <= dmi_read_word;
            VALID_ADDRESS_O <= ADDR_DMI;
            read_pending_q  <= 1'b0;
         end else if (read_accept) begin
            if (defer_read) begin
               read_pending_q <= 1'b1;
            end else begin
               READ_VALID_O    <= 1'b1;
               READ_DATA_O     <= read_word;
               VALID_ADDRESS_O <= READ_ADDRESS_I;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmi_uart_dtm_ctrl.sv
// Self-checking bench for dmi_uart_dtm_ctrl: fixed read table, directed
// DMI/error/hard-reset sequences and randomized traffic against a model.
module tb_dmi_uart_dtm_ctrl;
   import uart_pkg::*;

   localparam int WIDTH = 41;
   localparam int ABITS = 7;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [IRLENGTH-1:0] write_address;
   logic [WIDTH-1:0]    write_data;
   logic                write_valid;
   logic                write_ready;
   logic [IRLENGTH-1:0] read_address;
   logic                read_ready;
   logic [WIDTH-1:0]    read_data;
   logic                read_valid;
   logic [IRLENGTH-1:0] valid_address;
   logic                hard_reset;
   logic [1:0]          dmi_error;
   logic [ABITS-1:0]    req_addr;
   logic [31:0]         req_data;
   logic [1:0]          req_op;
   logic                req_valid;
   logic                req_ready;
   logic [31:0]         resp_data;
   logic [1:0]          resp_op;
   logic                resp_valid;
   logic                resp_ready;

   int checks   = 0;
   int failures = 0;

   logic [1:0]       m_err;
   logic [WIDTH-1:0] m_result;

   typedef struct {
      logic [IRLENGTH-1:0] addr;
      logic [WIDTH-1:0]    expected;
   } read_vec_t;

   read_vec_t           vectors[5];
   logic [IRLENGTH-1:0] other_addrs[4];

   always #5 clk = ~clk;

   dmi_uart_dtm_ctrl #(.WIDTH(WIDTH), .ABITS(ABITS), .IDCODE_VALUE(32'h0000_0001)) dut (
      .CLK_I(clk), .RST_NI(rst_n),
      .WRITE_ADDRESS_I(write_address), .WRITE_DATA_I(write_data),
      .WRITE_VALID_I(write_valid), .WRITE_READY_O(write_ready),
      .READ_ADDRESS_I(read_address), .READ_READY_I(read_ready),
      .READ_DATA_O(read_data), .READ_VALID_O(read_valid),
      .VALID_ADDRESS_O(valid_address), .DMI_HARD_RESET_I(hard_reset),
      .DMI_ERROR_O(dmi_error),
      .DMI_REQ_ADDR_O(req_addr), .DMI_REQ_DATA_O(req_data), .DMI_REQ_OP_O(req_op),
      .DMI_REQ_VALID_O(req_valid), .DMI_REQ_READY_I(req_ready),
      .DMI_RESP_DATA_I(resp_data), .DMI_RESP_OP_I(resp_op),
      .DMI_RESP_VALID_I(resp_valid), .DMI_RESP_READY_O(resp_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Expected register views derived from the sticky error and last result.
   function automatic logic [WIDTH-1:0] model_dtmcs();
      return WIDTH'(32'h1001) + WIDTH'(ABITS) * 16 + WIDTH'(m_err) * 1024;
   endfunction

   function automatic logic [WIDTH-1:0] model_dmi_read();
      logic [WIDTH-1:0] r;
      r = m_result;
      if (m_err != 2'd0) r[1:0] = m_err;
      return r;
   endfunction

   task automatic apply_stimulus(input logic [IRLENGTH-1:0] addr, input logic [WIDTH-1:0] data);
      write_address = addr;
      write_data    = data;
      write_valid   = 1'b1;
      step();
      write_valid   = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [IRLENGTH-1:0] addr, input logic [WIDTH-1:0] expected);
      read_address = addr;
      read_ready   = 1'b1;
      step();
      read_ready   = 1'b0;
      check_output({name, "_valid"}, 64'(read_valid), 64'd1);
      check_output({name, "_data"}, 64'(read_data), 64'(expected));
      check_output({name, "_addr"}, 64'(valid_address), 64'(addr));
      step();
      check_output({name, "_pulse_end"}, 64'(read_valid), 64'd0);
   endtask

   task automatic respond(input logic [31:0] data, input logic [1:0] op);
      resp_data  = data;
      resp_op    = op;
      resp_valid = 1'b1;
      step();
      resp_valid = 1'b0;
   endtask

   task automatic model_capture(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] op);
      m_result = {a, d, (m_err != 2'd0) ? m_err : op};
      if (m_err == 2'd0 && op >= 2'd2) m_err = op;
   endtask

   task automatic dmi_transaction(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] op,
                                  input int delay, input logic [31:0] rd, input logic [1:0] rop, input int rdelay);
      logic launched;
      launched = ((op == 2'd1) || (op == 2'd2)) && (m_err == 2'd0);
      check_output("txn_write_ready", 64'(write_ready), 64'd1);
      apply_stimulus(ADDR_DMI, {a, d, op});
      if (launched) begin
         check_output("txn_req_valid", 64'(req_valid), 64'd1);
         check_output("txn_req_fields", 64'({req_addr, req_data, req_op}), 64'({a, d, op}));
         for (int i = 0; i < delay; i++) begin
            step();
            check_output("txn_req_hold", 64'({req_valid, req_addr, req_data, req_op}), 64'({1'b1, a, d, op}));
            check_output("txn_wr_ready_req", 64'(write_ready), 64'd0);
         end
         req_ready = 1'b1;
         step();
         req_ready = 1'b0;
         check_output("txn_req_drop", 64'(req_valid), 64'd0);
         for (int i = 0; i < rdelay; i++) begin
            check_output("txn_resp_ready", 64'(resp_ready), 64'd1);
            step();
         end
         check_output("txn_resp_ready", 64'(resp_ready), 64'd1);
         respond(rd, rop);
         model_capture(a, rd, rop);
         check_output("txn_idle", 64'({resp_ready, write_ready}), 64'({1'b0, 1'b1}));
      end else begin
         check_output("txn_ignored", 64'({req_valid, write_ready}), 64'({1'b0, 1'b1}));
      end
      check_output("txn_error", 64'(dmi_error), 64'(m_err));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int pulses;
      int adjacent;
      logic prev;
      logic [IRLENGTH-1:0] raddr;
      logic [WIDTH-1:0] wbits;

      rst_n = 1'b0; write_address = '0; write_data = '0; write_valid = 1'b0;
      read_address = '0; read_ready = 1'b0; hard_reset = 1'b0; req_ready = 1'b0;
      resp_data = '0; resp_op = 2'd0; resp_valid = 1'b0;
      m_err = 2'd0; m_result = '0;

      vectors[0] = '{ADDR_IDCODE, 41'h1};
      vectors[1] = '{ADDR_DTMCS,  41'h1071};
      vectors[2] = '{ADDR_DMI,    41'h0};
      vectors[3] = '{5'h00,       41'h0};
      vectors[4] = '{5'h1f,       41'h0};
      other_addrs[0] = 5'h00; other_addrs[1] = 5'h02;
      other_addrs[2] = 5'h0a; other_addrs[3] = 5'h1f;

      repeat (3) step();
      rst_n = 1'b1;
      step();
      check_output("reset_write_ready", 64'(write_ready), 64'd1);
      check_output("reset_outputs", 64'({read_valid, req_valid, resp_ready, dmi_error}), 64'd0);
      check_output("reset_read_data", 64'(read_data), 64'd0);
      check_output("reset_valid_addr", 64'(valid_address), 64'd0);
      check_output("reset_req_fields", 64'({req_addr, req_data, req_op}), 64'd0);

      for (int i = 0; i < 5; i++) do_read($sformatf("table_read%0d", i), vectors[i].addr, vectors[i].expected);

      // Delayed request handshake, successful write.
      dmi_transaction(7'h10, 32'hDEADBEEF, 2'd2, 3, 32'h0, 2'd0, 0);
      do_read("dmi_after_write", ADDR_DMI, {7'h10, 32'h0, 2'b00});

      // DMI read held pending while the transaction is in flight.
      apply_stimulus(ADDR_DMI, {7'h11, 32'h0, 2'd1});
      check_output("busy_rd_req_valid", 64'(req_valid), 64'd1);
      req_ready = 1'b1; step(); req_ready = 1'b0;
      read_address = ADDR_DMI; read_ready = 1'b1; step(); read_ready = 1'b0;
      check_output("pending_no_pulse0", 64'(read_valid), 64'd0);
      step();
      check_output("pending_no_pulse1", 64'(read_valid), 64'd0);
      respond(32'h12345678, 2'd0);
      model_capture(7'h11, 32'h12345678, 2'd0);
      check_output("pending_pulse", 64'(read_valid), 64'd1);
      check_output("pending_data", 64'(read_data), 64'({7'h11, 32'h12345678, 2'b00}));
      check_output("pending_addr", 64'(valid_address), 64'(ADDR_DMI));
      step();
      check_output("pending_pulse_end", 64'(read_valid), 64'd0);

      // Busy error from a write during RESP.
      apply_stimulus(ADDR_DMI, {7'h12, 32'hA5A5A5A5, 2'd2});
      req_ready = 1'b1; step(); req_ready = 1'b0;
      check_output("resp_write_ready", 64'(write_ready), 64'd1);
      apply_stimulus(ADDR_DMI, {7'h13, 32'h0, 2'd2});
      m_err = 2'd3;
      check_output("busy_error", 64'(dmi_error), 64'd3);
      check_output("busy_no_req", 64'(req_valid), 64'd0);
      respond(32'h0BADF00D, 2'd0);
      model_capture(7'h12, 32'h0BADF00D, 2'd0);
      check_output("busy_error_held", 64'(dmi_error), 64'd3);
      dmi_transaction(7'h14, 32'h1, 2'd2, 0, 32'h0, 2'd0, 0);
      do_read("dtmcs_busy", ADDR_DTMCS, model_dtmcs());
      do_read("dmi_busy_result", ADDR_DMI, {7'h12, 32'h0BADF00D, 2'd3});
      apply_stimulus(ADDR_DTMCS, 41'h20000);
      m_err = 2'd0;
      check_output("dmireset_clear", 64'(dmi_error), 64'd0);

      // Failed response, then hard reset while a request is outstanding.
      dmi_transaction(7'h20, 32'h1, 2'd1, 1, 32'hCAFE, 2'd2, 1);
      check_output("failed_error", 64'(dmi_error), 64'd2);
      do_read("dtmcs_failed", ADDR_DTMCS, 41'h1871);
      apply_stimulus(ADDR_DTMCS, 41'h20000);
      m_err = 2'd0;
      apply_stimulus(ADDR_DMI, {7'h05, 32'h55, 2'd2});
      check_output("hr_req_valid", 64'(req_valid), 64'd1);
      hard_reset = 1'b1; step(); hard_reset = 1'b0;
      m_err = 2'd0; m_result = '0;
      check_output("hr_req_drop", 64'({req_valid, write_ready, dmi_error}), 64'({1'b0, 1'b1, 2'd0}));
      do_read("hr_result_cleared", ADDR_DMI, 41'h0);

      // Hard reset clears a nonzero error from idle.
      dmi_transaction(7'h21, 32'h2, 2'd2, 0, 32'h9, 2'd3, 0);
      hard_reset = 1'b1; step(); hard_reset = 1'b0;
      m_err = 2'd0; m_result = '0;
      check_output("hr_idle_error", 64'(dmi_error), 64'd0);

      // Hard reset during RESP drains the response without recording it.
      apply_stimulus(ADDR_DMI, {7'h22, 32'h3, 2'd1});
      req_ready = 1'b1; step(); req_ready = 1'b0;
      apply_stimulus(ADDR_DTMCS, 41'h10000);
      check_output("drain_resp_ready", 64'(resp_ready), 64'd1);
      respond(32'h77, 2'd2);
      check_output("drain_done", 64'({resp_ready, write_ready, dmi_error}), 64'({1'b0, 1'b1, 2'd0}));
      do_read("drain_discarded", ADDR_DMI, 41'h0);

      // Continuous read on IDCODE.
      pulses = 0; adjacent = 0; prev = 1'b0;
      read_address = ADDR_IDCODE; read_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (read_valid) begin
            pulses++;
            if (prev) adjacent++;
         end
         prev = read_valid;
      end
      read_ready = 1'b0;
      check_output("cont_pulses", 64'(pulses), 64'd10);
      check_output("cont_adjacent", 64'(adjacent), 64'd0);
      step();
      step();

      // Randomized traffic against the model.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               case ($urandom_range(0, 3))
                  0: do_read("rnd_idcode", ADDR_IDCODE, 41'h1);
                  1: do_read("rnd_dtmcs", ADDR_DTMCS, model_dtmcs());
                  2: do_read("rnd_dmi", ADDR_DMI, model_dmi_read());
                  default: begin
                     raddr = other_addrs[$urandom_range(0, 3)];
                     do_read("rnd_other", raddr, 41'h0);
                  end
               endcase
            end
            1, 2: dmi_transaction(7'($urandom), $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                                  $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
            default: begin
               wbits = {9'($urandom), $urandom};
               apply_stimulus(ADDR_DTMCS, wbits);
               if (wbits[16]) begin
                  m_err = 2'd0;
                  m_result = '0;
               end else if (wbits[17]) begin
                  m_err = 2'd0;
               end
               check_output("rnd_dtmcs_write_error", 64'(dmi_error), 64'(m_err));
            end
         endcase
      end
      do_read("final_dmi", ADDR_DMI, model_dmi_read());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmi_uart_dtm_ctrl.md
# dmi_uart_dtm_ctrl

Debug-transport register controller that sits between `DMI_UART_TAP` and the RISC-V debug module. It serves the TAP's register write and read handshakes for IDCODE, DTMCS and DMI. It sequences exactly one outstanding DMI request/response transaction at a time. It maintains the sticky DMI error state reported back to the TAP.

## Interface
- `WIDTH`, 41: TAP register width. Must equal `ABITS+34`.
- `ABITS`, 7: DMI address bits.
- `IDCODE_VALUE`, 32'h0000_0001: value returned for `ADDR_IDCODE`, zero-extended to `WIDTH`.
- `CLK_I` in 1: clock. One clock only.
- `RST_NI` in 1: reset. Synchronous, active-low.
- `WRITE_ADDRESS_I` in `IRLENGTH`: TAP write target address.
- `WRITE_DATA_I` in `WIDTH`: TAP write data.
- `WRITE_VALID_I` in 1: TAP write request.
- `WRITE_READY_O` out 1: write accepted when both valid and ready are high.
- `READ_ADDRESS_I` in `IRLENGTH`: TAP read target address.
- `READ_READY_I` in 1: TAP read request.
- `READ_DATA_O` out `WIDTH`: read result.
- `READ_VALID_O` out 1: one-cycle pulse; `READ_DATA_O` is valid in this cycle.
- `VALID_ADDRESS_O` out `IRLENGTH`: address whose data is currently held in `READ_DATA_O`.
- `DMI_HARD_RESET_I` in 1: hard reset request from the TAP.
- `DMI_ERROR_O` out 2: sticky error (0 ok, 2 failed, 3 busy).
- `DMI_REQ_ADDR_O` out `ABITS`: DMI request address.
- `DMI_REQ_DATA_O` out 32: DMI request data.
- `DMI_REQ_OP_O` out 2: DMI request op.
- `DMI_REQ_VALID_O` out 1: DMI request valid.
- `DMI_REQ_READY_I` in 1: DMI request accepted by the debug module.
- `DMI_RESP_DATA_I` in 32: DMI response data.
- `DMI_RESP_OP_I` in 2: DMI response status.
- `DMI_RESP_VALID_I` in 1: DMI response valid.
- `DMI_RESP_READY_O` out 1: controller ready for a DMI response.

## Operation
- **FSM states:** IDLE, REQ, RESP.
  - IDLE→REQ: accepted DMI write with op 1 (read) or 2 (write) while sticky error is 0.
  - REQ→RESP: `DMI_REQ_READY_I` is high.
  - RESP→IDLE: `DMI_RESP_VALID_I` is high; the response is captured.
- **Write-word fields** (`WRITE_DATA_I` / DMI register layout): op = [1:0], data = [33:2], addr = [WIDTH-1:34].
- **Write ready:** `WRITE_READY_O` = 1 in IDLE and RESP; 0 in REQ.
- **Accepted writes, by address:**
  - `ADDR_DMI` in IDLE: launches the request only if op is 1 or 2 and sticky error is 0; otherwise the write is ignored.
  - `ADDR_DMI` in RESP: dropped; sticky error becomes 3 if it was 0.
  - `ADDR_DTMCS`: bit16 (dmihardreset) acts as `DMI_HARD_RESET_I`; bit17 (dmireset) clears sticky error. Other bits are ignored.
  - Any other address: accepted and ignored.
- **Response capture:** result register = `{req_addr, DMI_RESP_DATA_I, op}`, where op = sticky error if nonzero, else `DMI_RESP_OP_I`. A response op of 2 or 3 sets sticky error to that value if sticky error was 0.
- **Reads:** `READ_READY_I` high in a cycle when no read is pending registers a read of `READ_ADDRESS_I`.
  - `ADDR_IDCODE`: `IDCODE_VALUE`.
  - `ADDR_DTMCS`: `{idle=3'd1 at [14:12], dmistat=sticky error at [11:10], abits=ABITS at [9:4], version=4'd1 at [3:0]}`, all other bits 0.
  - `ADDR_DMI`: result register with [1:0] replaced by the sticky error if nonzero. While the FSM is not IDLE, the read is held pending until the return to IDLE.
  - Any other address: all zeros.
- **Hard reset** (`DMI_HARD_RESET_I` or DTMCS bit16):
  - Sticky error and result register are cleared.
  - REQ→IDLE immediately; `DMI_REQ_VALID_O` drops.
  - RESP stays in RESP; the response is drained with the ready signal high and discarded.
- **Simultaneous events:** if a read of `ADDR_DMI` and the response arrive in the same cycle, the read returns the new result. A hard reset in the same cycle as a DMI write wins; the write is dropped.

## Timing
- **Reset values:** all outputs 0 except `WRITE_READY_O`=1. `VALID_ADDRESS_O`=0. FSM in IDLE, sticky error 0, result register 0.
- **DMI request:** `DMI_REQ_*` are registered. `DMI_REQ_VALID_O` rises the cycle after the accepted write, then stays high with stable fields until `DMI_REQ_READY_I`.
- **DMI response:** `DMI_RESP_READY_O`=1 exactly in RESP.
- **Read latency:** IDCODE/DTMCS/other and DMI-in-IDLE reads give `READ_VALID_O` exactly 1 cycle after `READ_READY_I` is sampled. A pending DMI read gives `READ_VALID_O` 1 cycle after response capture.
- **Read data holding:** `READ_DATA_O` and `VALID_ADDRESS_O` are updated together with the pulse and held until the next pulse.
- **Continuous read:** `READ_VALID_O` never fires on consecutive cycles; a held `READ_READY_I` yields one pulse every 2 cycles.
- **Sticky error:** updates on the clock edge after the causing event.

## Structure
- **`uart_pkg`** holds `IRLENGTH` and `ADDR_IDCODE`/`ADDR_DTMCS`/`ADDR_DMI`, plus new entries:
  - `dmi_op_e` (NOP=0, READ=1, WRITE=2); response status OK=0, FAILED=2, BUSY=3;
  - DTMCS bit-position constants;
  - `dtm_state_e`.
- **Sub-modules:** none; the FSM, result register and read mux are inline.

## Test plan
- **Reads:** reset, then read `ADDR_IDCODE` -> `READ_VALID_O` 1 cycle later with data 41'h1 and `VALID_ADDRESS_O`=`ADDR_IDCODE`. Read `ADDR_DTMCS` -> 41'h1071.
- **DMI write, delayed handshake:** write `ADDR_DMI` with addr 7'h10, data 32'hDEADBEEF, op 2; hold `DMI_REQ_READY_I` low 3 cycles -> `DMI_REQ_*` stable throughout. Then return response op 0 -> FSM returns to IDLE and `DMI_ERROR_O`=0.
- **DMI read while busy:** DMI read op 1 to addr 7'h11, then read `ADDR_DMI` while in RESP -> no pulse until the response arrives with data 32'h12345678, then a pulse with data {7'h11, 32'h12345678, 2'b00}.
- **Busy error:** a DMI write while in RESP -> `DMI_ERROR_O`=3 and no new request. A further op-2 write is ignored. DTMCS write with bit17 set -> error 0.
- **Failed response and hard reset:** response op 2 -> `DMI_ERROR_O`=2 and DTMCS dmistat=2. `DMI_HARD_RESET_I` pulse in REQ -> `DMI_REQ_VALID_O`=0 the next cycle and error 0.
- **Continuous read:** `READ_READY_I` held high for 20 cycles on `ADDR_IDCODE` -> exactly 10 pulses, none adjacent.
